// File: rtl/game_pkg.sv
// Shared game-flow definitions: state encoding and small elaboration-time helpers.
package game_pkg;

    localparam int GS_W = 4;

    typedef enum logic [GS_W-1:0] {
        GS_IDLE     = 4'd0,
        GS_RELOAD   = 4'd1,
        GS_READY    = 4'd2,
        GS_PLAY     = 4'd3,
        GS_PAUSE    = 4'd4,
        GS_DYING    = 4'd5,
        GS_CLEAR    = 4'd6,
        GS_GAMEOVER = 4'd7
    } game_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with a zero flag; shared by the timed game phases.
module phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] count;

    // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_val;
        end else if (i_dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign o_zero = (count == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level Pac-Man game sequencer: reload handshake, timed READY/DYING phases,
// play/pause, level clear and game over with lives/level bookkeeping.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int NUM_RELOAD      = 2,
    parameter int LEVEL_W         = 8,
    parameter int LIVES_W         = 4,
    parameter int START_LIVES     = 3,
    parameter int MAX_LIVES       = 5,
    parameter int READY_CYCLES    = 120,
    parameter int DYING_CYCLES    = 90,
    parameter int GAMEOVER_CYCLES = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_game_start,
    input  logic                  i_game_pause,
    input  logic [NUM_RELOAD-1:0] i_reload_done,
    input  logic                  i_pacman_eaten,
    input  logic                  i_dot_clear,
    input  logic                  i_extra_life,
    output logic [GS_W-1:0]       o_game_state,
    output logic [NUM_RELOAD-1:0] o_reload_req,
    output logic                  o_actor_reload,
    output logic [LEVEL_W-1:0]    o_level,
    output logic [LIVES_W-1:0]    o_lives
);

    localparam int TIMER_W = $clog2(max3(READY_CYCLES, DYING_CYCLES, GAMEOVER_CYCLES)) + 1;
    localparam bit GO_AUTO = (GAMEOVER_CYCLES > 0);

    localparam logic [TIMER_W-1:0] READY_LOAD    = TIMER_W'(READY_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DYING_LOAD    = TIMER_W'(DYING_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAMEOVER_LOAD = GO_AUTO ? TIMER_W'(GAMEOVER_CYCLES - 1) : '0;

    localparam logic [LIVES_W-1:0] START_L   = LIVES_W'(START_LIVES);
    localparam logic [LIVES_W-1:0] MAX_L     = LIVES_W'(MAX_LIVES);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(1);

    game_state_t           state;
    logic [NUM_RELOAD-1:0] mask;
    logic [NUM_RELOAD-1:0] mask_next;
    logic                  reload_complete;
    logic                  play_die;
    logic                  dying_expired;
    logic                  to_ready;
    logic                  to_gameover;
    logic                  timer_load;
    logic [TIMER_W-1:0]    timer_val;
    logic                  timer_dec;
    logic                  timer_zero;

    // Transition events shared by the FSM and the timer command logic.
    assign mask_next       = mask | i_reload_done;
    assign reload_complete = (state == GS_RELOAD) && (&mask_next);
    assign play_die        = (state == GS_PLAY) && !i_game_pause && i_pacman_eaten;
    assign dying_expired   = (state == GS_DYING) && timer_zero;
    assign to_gameover     = dying_expired && (o_lives == '0);
    assign to_ready        = reload_complete || (dying_expired && (o_lives != '0));

    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        if (to_ready) begin
            timer_load = 1'b1;
            timer_val  = READY_LOAD;
        end else if (play_die) begin
            timer_load = 1'b1;
            timer_val  = DYING_LOAD;
        end else if (to_gameover && GO_AUTO) begin
            timer_load = 1'b1;
            timer_val  = GAMEOVER_LOAD;
        end
    end

    assign timer_dec = (state == GS_READY) || (state == GS_DYING) || (state == GS_GAMEOVER);

    phase_timer #(
        .WIDTH (TIMER_W)
    ) u_phase_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (timer_load),
        .i_load_val (timer_val),
        .i_dec      (timer_dec),
        .o_zero     (timer_zero)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= GS_IDLE;
            mask           <= '0;
            o_reload_req   <= '0;
            o_actor_reload <= 1'b0;
            o_level        <= LEVEL_ONE;
            o_lives        <= START_L;
        end else begin
            o_actor_reload <= 1'b0;
            case (state)
                GS_IDLE: begin
                    if (i_game_start) begin
                        state        <= GS_RELOAD;
                        o_reload_req <= '1;
                        mask         <= '0;
                        o_level      <= LEVEL_ONE;
                        o_lives      <= START_L;
                    end
                end
                GS_RELOAD: begin
                    mask         <= mask_next;
                    o_reload_req <= o_reload_req & ~i_reload_done;
                    if (reload_complete) begin
                        state          <= GS_READY;
                        o_actor_reload <= 1'b1;
                    end
                end
                GS_READY: begin
                    if (timer_zero) state <= GS_PLAY;
                end
                GS_PLAY: begin
                    // Extra life is banked whichever way play exits this cycle.
                    if (i_extra_life && (o_lives < MAX_L)) o_lives <= o_lives + 1'b1;
                    if (i_game_pause)        state <= GS_PAUSE;
                    else if (i_pacman_eaten) state <= GS_DYING;
                    else if (i_dot_clear)    state <= GS_CLEAR;
                end
                GS_PAUSE: begin
                    if (i_game_pause) state <= GS_PLAY;
                end
                GS_DYING: begin
                    if (timer_zero) begin
                        if (o_lives == '0) begin
                            state <= GS_GAMEOVER;
                        end else begin
                            o_lives        <= o_lives - 1'b1;
                            state          <= GS_READY;
                            o_actor_reload <= 1'b1;
                        end
                    end
                end
                GS_CLEAR: begin
                    if (i_game_start) begin
                        if (o_level != '1) o_level <= o_level + 1'b1;
                        o_reload_req <= '1;
                        mask         <= '0;
                        state        <= GS_RELOAD;
                    end
                end
                GS_GAMEOVER: begin
                    if (i_game_start || (GO_AUTO && timer_zero)) state <= GS_IDLE;
                end
                default: state <= GS_IDLE;
            endcase
        end
    end

    assign o_game_state = state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: directed scenarios plus random play against a phase-level model.
module tb_game_flow_ctrl;
    import game_pkg::*;

    localparam int NR    = 3;
    localparam int LVW   = 2;
    localparam int LW    = 4;
    localparam int START = 3;
    localparam int MAXL  = 5;
    localparam int RDY   = 4;
    localparam int DYC   = 3;
    localparam int GOC   = 5;
    localparam int LVL_MAX = (1 << LVW) - 1;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_game_start, i_game_pause, i_pacman_eaten, i_dot_clear, i_extra_life;
    logic [NR-1:0] i_reload_done;
    logic [3:0]    o_game_state;
    logic [NR-1:0] o_reload_req;
    logic          o_actor_reload;
    logic [LVW-1:0] o_level;
    logic [LW-1:0] o_lives;

    always #5 i_clk = ~i_clk;

    game_flow_ctrl #(
        .NUM_RELOAD(NR), .LEVEL_W(LVW), .LIVES_W(LW), .START_LIVES(START), .MAX_LIVES(MAXL),
        .READY_CYCLES(RDY), .DYING_CYCLES(DYC), .GAMEOVER_CYCLES(GOC)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_game_start(i_game_start), .i_game_pause(i_game_pause),
        .i_reload_done(i_reload_done), .i_pacman_eaten(i_pacman_eaten), .i_dot_clear(i_dot_clear),
        .i_extra_life(i_extra_life), .o_game_state(o_game_state), .o_reload_req(o_reload_req),
        .o_actor_reload(o_actor_reload), .o_level(o_level), .o_lives(o_lives)
    );

    typedef struct packed {
        logic [3:0]     st;
        logic [NR-1:0]  req;
        logic           act;
        logic [LVW-1:0] lvl;
        logic [LW-1:0]  lives;
    } obs_t;

    obs_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Phase-level reference: cycles left in the current timed phase, set of channels still pending.
    game_state_t m_state;
    int          m_left;
    bit [NR-1:0] m_pending;
    int          m_level;
    int          m_lives;
    bit          m_act;

    function automatic void model_reset();
        m_state = GS_IDLE; m_left = 0; m_pending = '0;
        m_level = 1; m_lives = START; m_act = 1'b0;
    endfunction

    function automatic void enter_ready();
        m_state = GS_READY; m_left = RDY; m_act = 1'b1;
    endfunction

    function automatic void model_step(input bit st, input bit pa, input bit [NR-1:0] dn,
                                       input bit ea, input bit dc, input bit xl);
        m_act = 1'b0;
        case (m_state)
            GS_IDLE: if (st) begin
                m_state = GS_RELOAD; m_pending = '1; m_level = 1; m_lives = START;
            end
            GS_RELOAD: begin
                m_pending = m_pending & ~dn;
                if (m_pending == '0) enter_ready();
            end
            GS_READY: begin
                m_left--;
                if (m_left == 0) m_state = GS_PLAY;
            end
            GS_PLAY: begin
                if (xl) m_lives = (m_lives + 1 > MAXL) ? MAXL : m_lives + 1;
                if (pa)      m_state = GS_PAUSE;
                else if (ea) begin m_state = GS_DYING; m_left = DYC; end
                else if (dc) m_state = GS_CLEAR;
            end
            GS_PAUSE: if (pa) m_state = GS_PLAY;
            GS_DYING: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_lives == 0) begin
                        m_state = GS_GAMEOVER; m_left = GOC;
                    end else begin
                        m_lives--; enter_ready();
                    end
                end
            end
            GS_CLEAR: if (st) begin
                m_level = (m_level + 1 > LVL_MAX) ? LVL_MAX : m_level + 1;
                m_pending = '1; m_state = GS_RELOAD;
            end
            GS_GAMEOVER: begin
                m_left--;
                if (st || m_left == 0) m_state = GS_IDLE;
            end
            default: m_state = GS_IDLE;
        endcase
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.st    = m_state;
        o.req   = m_pending;
        o.act   = m_act;
        o.lvl   = LVW'(m_level);
        o.lives = LW'(m_lives);
        return o;
    endfunction

    // Monitor: one expected observation per clock edge, compared just after the edge.
    initial begin
        obs_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mon_state", o_game_state, e.st);
                check("mon_req", o_reload_req, e.req);
                check("mon_actor", o_actor_reload, e.act);
                check("mon_level", o_level, e.lvl);
                check("mon_lives", o_lives, e.lives);
            end
        end
    end

    task automatic cyc(input bit st = 0, input bit pa = 0, input bit [NR-1:0] dn = '0,
                       input bit ea = 0, input bit dc = 0, input bit xl = 0);
        i_game_start = st; i_game_pause = pa; i_reload_done = dn;
        i_pacman_eaten = ea; i_dot_clear = dc; i_extra_life = xl;
        model_step(st, pa, dn, ea, dc, xl);
        exp_q.push_back(model_obs());
        @(negedge i_clk);
        i_game_start = 0; i_game_pause = 0; i_reload_done = '0;
        i_pacman_eaten = 0; i_dot_clear = 0; i_extra_life = 0;
    endtask

    task automatic run_until(input logic [3:0] tgt, input int budget, input string name);
        int n = 0;
        while (o_game_state !== tgt && n < budget) begin
            cyc();
            n++;
        end
        check(name, o_game_state, tgt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b1;
        i_game_start = 0; i_game_pause = 0; i_reload_done = '0;
        i_pacman_eaten = 0; i_dot_clear = 0; i_extra_life = 0;
        model_reset();
        repeat (2) @(negedge i_clk);
        check("rst_state", o_game_state, GS_IDLE);
        check("rst_req", o_reload_req, 0);
        check("rst_actor", o_actor_reload, 0);
        check("rst_level", o_level, 1);
        check("rst_lives", o_lives, START);
        i_rst = 1'b0;

        // Reload handshake with out-of-order channels, then READY timing.
        cyc(.st(1));
        check("t1_reload", o_game_state, GS_RELOAD);
        check("t1_req_all", o_reload_req, 3'b111);
        repeat (3) cyc();
        cyc(.dn(3'b001)); check("t1_req_ch0", o_reload_req, 3'b110);
        cyc();
        cyc(.dn(3'b100)); check("t1_req_ch2", o_reload_req, 3'b010);
        cyc();
        cyc(.dn(3'b010));
        check("t1_ready", o_game_state, GS_READY);
        check("t1_actor_hi", o_actor_reload, 1);
        check("t1_req_none", o_reload_req, 0);
        cyc(); check("t1_actor_lo", o_actor_reload, 0);
        cyc(); cyc(); check("t1_ready_last", o_game_state, GS_READY);
        cyc(); check("t1_play", o_game_state, GS_PLAY);

        // Eaten beats dot_clear; death costs one life.
        cyc(.ea(1), .dc(1)); check("t3_dying", o_game_state, GS_DYING);
        cyc(); cyc(); check("t3_dying_last", o_game_state, GS_DYING);
        cyc();
        check("t2_ready_again", o_game_state, GS_READY);
        check("t2_lives2", o_lives, 2);
        check("t2_actor", o_actor_reload, 1);
        run_until(GS_PLAY, 10, "t2_play");

        // Pause ignores eaten/clear and leaves counters alone.
        cyc(.pa(1)); check("t5_pause", o_game_state, GS_PAUSE);
        cyc(.ea(1), .dc(1)); check("t5_pause_hold", o_game_state, GS_PAUSE);
        cyc(.pa(1));
        check("t5_resume", o_game_state, GS_PLAY);
        check("t5_lives", o_lives, 2);
        check("t5_level", o_level, 1);

        // Level clear and next-level reload.
        cyc(.dc(1)); check("t3_clear", o_game_state, GS_CLEAR);
        cyc(.st(1));
        check("t3_reload", o_game_state, GS_RELOAD);
        check("t3_level2", o_level, 2);
        check("t3_req_all", o_reload_req, 3'b111);
        cyc(.dn(3'b111)); check("t5_ready", o_game_state, GS_READY);
        cyc(.pa(1)); check("t5_ready_nopause", o_game_state, GS_READY);
        cyc(); cyc(); check("t5_ready_last", o_game_state, GS_READY);
        cyc(); check("t5_play_on_time", o_game_state, GS_PLAY);

        // Extra lives saturate at MAX_LIVES.
        cyc(.xl(1)); check("t4_lives3", o_lives, 3);
        cyc(.xl(1)); check("t4_lives4", o_lives, 4);
        cyc(.xl(1)); check("t4_lives5", o_lives, 5);
        cyc(.xl(1)); check("t4_lives_sat", o_lives, 5);
        for (int k = 0; k < 3; k++) begin
            cyc(.ea(1));
            run_until(GS_PLAY, 20, "t4_back_to_play");
        end
        check("t4_lives_down", o_lives, 2);
        cyc(.ea(1), .xl(1));
        check("t4_dying_bonus", o_game_state, GS_DYING);
        check("t4_lives_bonus", o_lives, 3);
        run_until(GS_READY, 10, "t4_ready");
        check("t4_lives_after", o_lives, 2);
        run_until(GS_PLAY, 10, "t4_play");

        // Run out of lives, then game over auto-returns after GOC cycles.
        for (int k = 0; k < 2; k++) begin
            cyc(.ea(1));
            run_until(GS_PLAY, 20, "t2_play_loop");
        end
        check("t2_lives0", o_lives, 0);
        cyc(.ea(1));
        run_until(GS_GAMEOVER, 10, "t2_gameover");
        repeat (GOC - 1) cyc();
        check("t6_gameover_last", o_game_state, GS_GAMEOVER);
        cyc(); check("t6_auto_idle", o_game_state, GS_IDLE);

        // Asynchronous reset in the middle of a reload.
        cyc(.st(1));
        cyc(.dn(3'b111));
        run_until(GS_PLAY, 10, "t6_play");
        cyc(.xl(1));
        cyc(.dc(1));
        cyc(.st(1));
        cyc(.dn(3'b010));
        check("t6_req_101", o_reload_req, 3'b101);
        check("t6_level2", o_level, 2);
        #2 i_rst = 1'b1;
        #1;
        check("t6_async_state", o_game_state, GS_IDLE);
        check("t6_async_req", o_reload_req, 0);
        check("t6_async_level", o_level, 1);
        check("t6_async_lives", o_lives, START);
        model_reset();
        exp_q.push_back(model_obs());
        @(negedge i_clk);
        i_rst = 1'b0;

        // Random play against the model.
        for (int n = 0; n < 3000; n++) begin
            cyc(.st($urandom_range(0, 9) == 0),
                .pa($urandom_range(0, 19) == 0),
                .dn(NR'($urandom) & NR'($urandom)),
                .ea($urandom_range(0, 11) == 0),
                .dc($urandom_range(0, 15) == 0),
                .xl($urandom_range(0, 7) == 0));
        end

        @(negedge i_clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
